// File: rtl/multiword_adder_seq.sv
// Sequential multi-word adder/subtractor built around one WIDTH-bit prefix adder.
// The operand is processed one slice per clock, lowest slice first, with the
// inter-slice carry held in a register so no wide carry chain exists.

// Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module prefix_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] gen  [0:LEVELS];
  logic [WIDTH-1:0] prop [0:LEVELS];

  // Prefix tree; carry-in is folded into the bit-0 generate term.
  always_comb begin
    half    = a ^ b;
    gen[0]  = a & b;
    prop[0] = half;
    gen[0][0] = (a[0] & b[0]) | (half[0] & cin);
    for (int l = 0; l < int'(LEVELS); l++) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i >= (1 << l)) begin
          gen[l+1][i]  = gen[l][i] | (prop[l][i] & gen[l][i - (1 << l)]);
          prop[l+1][i] = prop[l][i] & prop[l][i - (1 << l)];
        end else begin
          gen[l+1][i]  = gen[l][i];
          prop[l+1][i] = prop[l][i];
        end
      end
    end
  end

  // Carry into each bit is the group generate of all lower bits.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i < int'(WIDTH); i++) begin
      carry[i] = gen[LEVELS][i-1];
    end
    s    = half ^ carry;
    cout = gen[LEVELS][WIDTH-1];
  end

endmodule

// Slice-serial wrapper: accepts a wide request, walks it through the adder,
// then presents the registered result until the consumer takes it.
module multiword_adder_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*WORDS-1:0]   in_a,
  input  logic [WIDTH*WORDS-1:0]   in_b,
  input  logic                     in_cin,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*WORDS-1:0]   out_sum,
  output logic                     out_cout,
  output logic                     out_ovf
);

  localparam int unsigned TOTAL = WIDTH * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [TOTAL-1:0] op_a;
  logic [TOTAL-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic             accept;
  logic             last_slice;
  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [WIDTH-1:0] slice_s;
  logic             slice_cout;

  // Request handshake and final-slice detect.
  always_comb begin
    accept     = 1'b0;
    last_slice = 1'b0;
    accept     = (state == S_IDLE) && in_valid;
    last_slice = (state == S_RUN) && (idx == LAST_IDX);
  end

  // Slice mux feeding the shared adder.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int w = 0; w < int'(WORDS); w++) begin
      if (idx == IDX_W'(w)) begin
        slice_a = op_a[w*int'(WIDTH) +: WIDTH];
        slice_b = op_b[w*int'(WIDTH) +: WIDTH];
      end
    end
  end

  prefix_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (idx == LAST_IDX) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Handshake flags are registered copies of the next state's decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
    end
  end

  // Operand capture; subtraction is A + ~B + ~borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (accept) begin
      op_a <= in_a;
      op_b <= in_sub ? ~in_b : in_b;
    end
  end

  // Carry chain register and slice index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      carry <= in_sub ? ~in_cin : in_cin;
      idx   <= '0;
    end else if (state == S_RUN) begin
      carry <= slice_cout;
      idx   <= last_slice ? '0 : idx + IDX_W'(1);
    end
  end

  // Result slices land one per RUN cycle; flags land on the top slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (state == S_RUN) begin
      for (int w = 0; w < int'(WORDS); w++) begin
        if (idx == IDX_W'(w)) begin
          out_sum[w*int'(WIDTH) +: WIDTH] <= slice_s;
        end
      end
      if (last_slice) begin
        out_cout <= slice_cout;
        out_ovf  <= (slice_a[WIDTH-1] == slice_b[WIDTH-1]) &&
                    (slice_s[WIDTH-1] != slice_a[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Scoreboard bench for multiword_adder_seq at WIDTH=32, WORDS=4.
module tb_multiword_adder_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned WORDS = 4;
  localparam int unsigned TOTAL = WIDTH * WORDS;

  typedef struct {
    logic [TOTAL-1:0] sum;
    logic             cout;
    logic             ovf;
    int               t0;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [TOTAL-1:0] in_a = '0;
  logic [TOTAL-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [TOTAL-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  exp_t q[$];

  multiword_adder_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [TOTAL-1:0] act, input logic [TOTAL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising out_valid consumes one scoreboard entry.
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_sum"}, out_sum, e.sum);
        chk({e.name, "_cout"}, out_cout, e.cout);
        chk({e.name, "_ovf"}, out_ovf, e.ovf);
        chk({e.name, "_latency"}, TOTAL'(cyc - e.t0), TOTAL'(WORDS));
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input string name, input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                      input logic cin, input logic sub,
                      input logic [TOTAL-1:0] es, input logic ec, input logic eo);
    exp_t e;
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    e.sum = es;
    e.cout = ec;
    e.ovf = eo;
    e.t0 = cyc;
    e.name = name;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset values while rst_n is low.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_cout", out_cout, 1'b0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    rst_n = 1'b1;

    send("all_ones_plus_one", {TOTAL{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
    send("inter_slice", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
         128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0);
    send("sub_borrow", 128'd5, 128'd7, 1'b0, 1'b1,
         128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    send("sub_noborrow", 128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0);
    send("signed_ovf_add", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
         128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
    send("sub_with_borrow_in", 128'd10, 128'd3, 1'b1, 1'b1, 128'd6, 1'b1, 1'b0);
    send("signed_ovf_sub", 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b0, 1'b1,
         128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    send("add_with_cin", 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, 128'd0, 1'b1, 1'b0,
         128'h0000_0000_0000_0002_0000_0000_0000_0000, 1'b0, 1'b0);

    // Backpressure: consumer stalls while new requests are offered.
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    send("backpressure", 128'd100, 128'd23, 1'b0, 1'b0, 128'd123, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 128'(i + 1000);
      in_b = 128'(i * 7);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_sum", out_sum, 128'd123);
      chk("bp_out_cout", out_cout, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;

    // Reset two cycles into a run discards the operation.
    send("discarded", {TOTAL{1'b1}}, {TOTAL{1'b1}}, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrun_rst_out_valid", out_valid, 1'b0);
    chk("midrun_rst_out_sum", out_sum, '0);
    chk("midrun_rst_in_ready", in_ready, 1'b1);
    chk("midrun_rst_out_cout", out_cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send("after_reset", 128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0, 1'b0);

    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 128'(q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
